// File: rtl/fdc_sd_sector_mover_if.sv
// Bundle of the FDC request port, SD-card byte-stream port and sector-buffer port A
// seen by the sector mover (master) and by whatever sits around it (slave).
interface fdc_sd_sector_mover_if #(
   parameter int BUF_AW = 10
) ();
   logic              req_rd;
   logic              req_wr;
   logic [31:0]       req_lba;
   logic              req_half;
   logic              busy;
   logic              done;
   logic              err;
   logic              sd_rd;
   logic              sd_wr;
   logic [31:0]       sd_lba;
   logic              sd_busy;
   logic              sd_err;
   logic [7:0]        sd_rd_data;
   logic              sd_rd_strobe;
   logic [7:0]        sd_wr_data;
   logic              sd_wr_strobe;
   logic [BUF_AW-1:0] buf_addr;
   logic [7:0]        buf_din;
   logic              buf_we;
   logic [7:0]        buf_dout;

   modport master (
      input  req_rd, req_wr, req_lba, req_half,
      input  sd_busy, sd_err, sd_rd_data, sd_rd_strobe, sd_wr_strobe,
      input  buf_dout,
      output busy, done, err,
      output sd_rd, sd_wr, sd_lba, sd_wr_data,
      output buf_addr, buf_din, buf_we
   );

   modport slave (
      output req_rd, req_wr, req_lba, req_half,
      output sd_busy, sd_err, sd_rd_data, sd_rd_strobe, sd_wr_strobe,
      output buf_dout,
      input  busy, done, err,
      input  sd_rd, sd_wr, sd_lba, sd_wr_data,
      input  buf_addr, buf_din, buf_we
   );
endinterface

// File: rtl/fdc_sd_sector_mover.sv
// Moves one sector between the SD byte-stream core and one half of the FDC
// ping-pong sector buffer (port A), in either direction.
module fdc_sd_sector_mover #(
   parameter int SECTOR_BYTES = 512,
   parameter int BUF_AW       = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   fdc_sd_sector_mover_if.master   bus
);
   localparam int CNT_W = $clog2(SECTOR_BYTES);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_DATA, WR_PRE1, WR_PRE2, WR_REQ, WR_DATA, FINISH
   } state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             take;
   logic             xfer_end;
   logic             half_q;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             full, full_nxt;
   logic             vld_p1, vld_p2;
   logic             zero_p1, zero_p2;

   assign accept = (state == IDLE) && (bus.req_rd || bus.req_wr);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // cnt counts modulo SECTOR_BYTES; full marks that the whole sector has gone by
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      xfer_end  = 1'b0;
      cnt_nxt   = cnt;
      full_nxt  = full;
      case (state)
         IDLE: begin
            if (bus.req_rd)      state_nxt = RD_REQ;
            else if (bus.req_wr) state_nxt = WR_PRE1;
         end
         RD_REQ:  if (bus.sd_busy) state_nxt = RD_DATA;
         RD_DATA: begin
            take = bus.sd_rd_strobe && !full;
            if (!bus.sd_busy) begin
               xfer_end  = 1'b1;
               state_nxt = FINISH;
            end
         end
         WR_PRE1: state_nxt = WR_PRE2;
         WR_PRE2: state_nxt = WR_REQ;
         WR_REQ:  if (bus.sd_busy) state_nxt = WR_DATA;
         WR_DATA: begin
            take = bus.sd_wr_strobe && !full;
            if (!bus.sd_busy) begin
               xfer_end  = 1'b1;
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (take) begin
         cnt_nxt = cnt + CNT_ONE;
         if (cnt == '1) full_nxt = 1'b1;
      end
   end

   assign bus.busy  = (state != IDLE) && (state != FINISH);
   assign bus.done  = (state == FINISH);
   assign bus.sd_rd = (state == RD_REQ);
   assign bus.sd_wr = (state == WR_REQ);

   // p0: strobe accepted, next buffer address issued; p1: buffer read; p2: byte to SD
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         full           <= 1'b0;
         bus.err        <= 1'b0;
         bus.sd_lba     <= '0;
         bus.sd_wr_data <= '0;
         bus.buf_addr   <= '0;
         bus.buf_din    <= '0;
         bus.buf_we     <= 1'b0;
         vld_p1         <= 1'b0;
         vld_p2         <= 1'b0;
      end else begin
         bus.buf_we <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= vld_p1;
         if (accept) begin
            bus.sd_lba   <= bus.req_lba;
            bus.buf_addr <= {bus.req_half, CNT_ZERO};
            cnt          <= '0;
            full         <= 1'b0;
            bus.err      <= 1'b0;
         end else begin
            cnt  <= cnt_nxt;
            full <= full_nxt;
         end
         if (state == RD_DATA && take) begin
            bus.buf_addr <= {half_q, cnt};
            bus.buf_din  <= bus.sd_rd_data;
            bus.buf_we   <= 1'b1;
         end
         if (state == WR_DATA && bus.sd_wr_strobe) begin
            vld_p1 <= 1'b1;
            if (!full) bus.buf_addr <= {half_q, cnt + CNT_ONE};
         end
         if (state == WR_PRE2)
            bus.sd_wr_data <= bus.buf_dout;
         else if (vld_p2)
            bus.sd_wr_data <= zero_p2 ? 8'h00 : bus.buf_dout;
         if (xfer_end)
            bus.err <= bus.sd_err || !(full_nxt && (cnt_nxt == '0));
      end
   end

   // Data-only state; qualified by accept / vld_p2 so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) half_q <= bus.req_half;
      if (state == WR_DATA && bus.sd_wr_strobe) zero_p1 <= full || (cnt == '1);
      zero_p2 <= zero_p1;
   end

endmodule

// File: tb/tb_fdc_sd_sector_mover.sv
// Directed bench for fdc_sd_sector_mover: a table of transfers against a modelled
// SD core and 1024x8 buffer, plus collision and mid-transfer reset sequences.
module tb_fdc_sd_sector_mover;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fill_req = 1'b0;

   fdc_sd_sector_mover_if bus ();

   fdc_sd_sector_mover dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        is_wr;
      logic [31:0] lba;
      bit        half;
      int        nbytes;
      int        gap;
      bit        sd_err;
      bit        exp_err;
      int        exp_we;
   } vec_t;

   logic [7:0] mem [1024];
   int we_cnt = 0;
   int done_cnt = 0;
   int sdwr_cnt = 0;
   int n_checks = 0;
   int n_fail = 0;

   function automatic logic [7:0] fill_byte(input int i);
      logic [7:0] b;
      b = i[7:0];
      return (i < 512) ? b : (b ^ 8'hC3);
   endfunction

   // Buffer model: registered read, one write port
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 1024; i++) mem[i] <= fill_byte(i);
      end else if (bus.buf_we) begin
         mem[bus.buf_addr] <= bus.buf_din;
      end
      bus.buf_dout <= mem[bus.buf_addr];
   end

   always @(posedge clk) begin
      if (bus.buf_we) we_cnt <= we_cnt + 1;
      if (bus.done)   done_cnt <= done_cnt + 1;
      if (bus.sd_wr)  sdwr_cnt <= sdwr_cnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic issue_req(input bit rd, input bit wr, input logic [31:0] lba, input bit half);
      @(posedge clk); #1 fill_req = 1'b1;
      @(posedge clk); #1 fill_req = 1'b0;
      bus.req_rd = rd; bus.req_wr = wr; bus.req_lba = lba; bus.req_half = half;
      @(posedge clk); #1 bus.req_rd = 1'b0; bus.req_wr = 1'b0;
   endtask

   task automatic check_mem(input vec_t v, input int nw);
      int bad_sel, bad_oth;
      logic [7:0] e;
      bad_sel = 0; bad_oth = 0;
      for (int i = 0; i < 1024; i++) begin
         e = fill_byte(i);
         if (!v.is_wr && ((i / 512) == int'(v.half)) && ((i % 512) < nw))
            e = (i % 256) ^ 8'h5A;
         if (mem[i] !== e) begin
            if ((i / 512) == int'(v.half)) bad_sel++;
            else bad_oth++;
         end
      end
      check("mem_selected_half_bad_bytes", bad_sel, 0);
      check("mem_other_half_bad_bytes", bad_oth, 0);
   endtask

   // Plays the SD core for one transfer already requested; abort_at >= 0 asserts
   // reset together with that read strobe.
   task automatic run_vec(input vec_t v, input int abort_at);
      int we0, dn0, nw, bad;
      bit seen;
      logic [7:0] eb;
      we0 = we_cnt; dn0 = done_cnt; bad = 0;
      nw = (v.nbytes < 512) ? v.nbytes : 512;
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (v.is_wr ? bus.sd_wr : bus.sd_rd) begin seen = 1'b1; break; end
      end
      check("sd_request_seen", seen, 1);
      check("sd_lba", bus.sd_lba, v.lba);
      check("busy_during", bus.busy, 1);
      if (v.is_wr) check("wr_first_byte", bus.sd_wr_data, fill_byte(v.half * 512));
      @(posedge clk); #1 bus.sd_busy = 1'b1;
      @(posedge clk); #1;
      check("sd_request_dropped", v.is_wr ? bus.sd_wr : bus.sd_rd, 0);
      for (int k = 0; k < v.nbytes; k++) begin
         repeat (v.gap - 1) begin @(posedge clk); #1; end
         if (v.is_wr) bus.sd_wr_strobe = 1'b1;
         else begin
            bus.sd_rd_strobe = 1'b1;
            bus.sd_rd_data = (k % 256) ^ 8'h5A;
         end
         if (k == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check("abort_buf_we", bus.buf_we, 0);
            check("abort_sd_rd", bus.sd_rd, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_sd_lba", bus.sd_lba, 0);
            check("abort_buf_addr", bus.buf_addr, 0);
            reset = 1'b0; bus.sd_rd_strobe = 1'b0; bus.sd_busy = 1'b0;
            repeat (10) @(negedge clk);
            check("abort_no_done", done_cnt - dn0, 0);
            check("abort_writes", we_cnt - we0, abort_at);
            return;
         end
         if (v.is_wr) begin
            @(negedge clk);
            eb = (k < 512) ? fill_byte(v.half * 512 + k) : 8'h00;
            if (bus.sd_wr_data !== eb) begin
               if (bad == 0) $display("first bad write byte %0d: got 0x%0h want 0x%0h", k, bus.sd_wr_data, eb);
               bad++;
            end
         end
         @(posedge clk); #1 bus.sd_rd_strobe = 1'b0; bus.sd_wr_strobe = 1'b0;
      end
      if (v.is_wr) check("wr_stream_bad_bytes", bad, 0);
      repeat (2) begin @(posedge clk); #1; end
      bus.sd_err = v.sd_err; bus.sd_busy = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            check("err_with_done", bus.err, v.exp_err);
            check("busy_low_with_done", bus.busy, 0);
            break;
         end
      end
      check("done_seen", seen, 1);
      #1 bus.sd_err = 1'b0;
      repeat (3) @(negedge clk);
      check("err_held", bus.err, v.exp_err);
      check("done_pulses", done_cnt - dn0, 1);
      check("buf_we_count", we_cnt - we0, v.exp_we);
      check("idle_after", bus.busy, 0);
      check_mem(v, v.is_wr ? 0 : nw);
   endtask

   vec_t vecs [7];
   vec_t vx;
   int wr0, dn0;

   initial begin
      // is_wr, lba, half, nbytes, gap, sd_err, exp_err, exp_we
      vecs[0] = '{1'b0, 32'h1234, 1'b1, 512, 4, 1'b0, 1'b0, 512};
      vecs[1] = '{1'b1, 32'h0007, 1'b0, 512, 3, 1'b0, 1'b0, 0};
      vecs[2] = '{1'b0, 32'h0055, 1'b0, 300, 4, 1'b0, 1'b1, 300};
      vecs[3] = '{1'b0, 32'h0099, 1'b0, 520, 3, 1'b0, 1'b0, 512};
      vecs[4] = '{1'b1, 32'hABCD, 1'b1, 300, 3, 1'b0, 1'b1, 0};
      vecs[5] = '{1'b1, 32'h0BAD, 1'b1, 520, 3, 1'b0, 1'b0, 0};
      vecs[6] = '{1'b0, 32'hFEED, 1'b0, 512, 3, 1'b1, 1'b1, 512};

      bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.req_lba = '0; bus.req_half = 1'b0;
      bus.sd_busy = 1'b0; bus.sd_err = 1'b0; bus.sd_rd_data = '0;
      bus.sd_rd_strobe = 1'b0; bus.sd_wr_strobe = 1'b0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_sd_rd", bus.sd_rd, 0);
      check("rst_sd_wr", bus.sd_wr, 0);
      check("rst_sd_lba", bus.sd_lba, 0);
      check("rst_sd_wr_data", bus.sd_wr_data, 0);
      check("rst_buf_addr", bus.buf_addr, 0);
      check("rst_buf_din", bus.buf_din, 0);
      check("rst_buf_we", bus.buf_we, 0);

      for (int i = 0; i < 7; i++) begin
         issue_req(!vecs[i].is_wr, vecs[i].is_wr, vecs[i].lba, vecs[i].half);
         run_vec(vecs[i], -1);
      end

      // Simultaneous read and write request, then a write request while busy
      wr0 = sdwr_cnt; dn0 = done_cnt;
      vx = '{1'b0, 32'h0042, 1'b0, 512, 3, 1'b0, 1'b0, 512};
      issue_req(1'b1, 1'b1, 32'h0042, 1'b0);
      bus.req_wr = 1'b1; bus.req_lba = 32'h0077; bus.req_half = 1'b1;
      @(posedge clk); #1 bus.req_wr = 1'b0;
      run_vec(vx, -1);
      check("collision_no_sd_wr", sdwr_cnt - wr0, 0);
      check("collision_single_done", done_cnt - dn0, 1);

      // Reset while byte 100 of a read arrives, then a clean read
      vx = '{1'b0, 32'h3333, 1'b0, 512, 3, 1'b0, 1'b0, 512};
      issue_req(1'b1, 1'b0, 32'h3333, 1'b0);
      run_vec(vx, 100);
      vx = '{1'b0, 32'h2222, 1'b1, 512, 3, 1'b0, 1'b0, 512};
      issue_req(1'b1, 1'b0, 32'h2222, 1'b1);
      run_vec(vx, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
